// File: rtl/alu_ctrl_fsm.sv
// Multicycle RV32I control sequencer: accepts one instruction over valid/ready,
// decodes it to an ALU op plus datapath strobes and walks DECODE/EXECUTE/MEM/WB.
module alu_ctrl_fsm (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   output logic        instr_ready_o,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic [3:0]  alu_op_o,
   output logic        alu_src_b_o,
   output logic        reg_write_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        pc_write_o,
   output logic        branch_taken_o,
   output logic        done_o,
   output logic        illegal_o
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 4;

   localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] S_DECODE  = 3'd1;
   localparam logic [STATE_W-1:0] S_EXECUTE = 3'd2;
   localparam logic [STATE_W-1:0] S_MEM     = 3'd3;
   localparam logic [STATE_W-1:0] S_WB      = 3'd4;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
   localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
   localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;

   logic [STATE_W-1:0] state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [OP_W-1:0]    alu_op_q, alu_op_d;
   logic               alu_src_b_q, alu_src_b_d;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            is_load;
   logic            is_store;
   logic            is_branch;
   logic            dec_legal;
   logic [OP_W-1:0] dec_op;
   logic            dec_src_b;
   logic            br_invert;
   logic            unused_fields;

   assign opcode    = instr_q[6:0];
   assign funct3    = instr_q[14:12];
   assign funct7    = instr_q[31:25];
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   // BNE/BLT/BLTU take the branch when the compare result is non-zero
   assign br_invert = funct3[0] ^ funct3[2];
   assign unused_fields = ^{instr_q[24:15], instr_q[11:7]};

   // Instruction decode from the captured word
   always_comb begin
      dec_legal = 1'b1;
      dec_op    = OP_ADD;
      dec_src_b = 1'b0;
      case (opcode)
         OPC_R: begin
            dec_op = {funct7[5], funct3};
            if (funct7 == F7_BASE) begin
               dec_legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
               dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
            end else begin
               dec_legal = 1'b0;
            end
         end
         OPC_I: begin
            dec_src_b = 1'b1;
            dec_op    = (funct3 == 3'b101 && instr_q[30]) ? OP_SRA : {1'b0, funct3};
         end
         OPC_LOAD, OPC_STORE: begin
            dec_src_b = 1'b1;
            dec_op    = OP_ADD;
         end
         OPC_BRANCH: begin
            case (funct3[2:1])
               2'b00:   dec_op = OP_SUB;
               2'b10:   dec_op = OP_SLT;
               2'b11:   dec_op = OP_SLTU;
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Next-state and Moore output decode
   always_comb begin
      state_d        = state_q;
      instr_d        = instr_q;
      alu_op_d       = alu_op_q;
      alu_src_b_d    = alu_src_b_q;
      instr_ready_o  = 1'b0;
      reg_write_o    = 1'b0;
      mem_read_o     = 1'b0;
      mem_write_o    = 1'b0;
      pc_write_o     = 1'b0;
      branch_taken_o = 1'b0;
      done_o         = 1'b0;
      illegal_o      = 1'b0;
      case (state_q)
         S_IDLE: begin
            instr_ready_o = 1'b1;
            if (instr_valid_i) begin
               instr_d = instr_i;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!dec_legal) begin
               illegal_o = 1'b1;
               state_d   = S_IDLE;
            end else begin
               alu_op_d    = dec_op;
               alu_src_b_d = dec_src_b;
               state_d     = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            if (is_branch) begin
               pc_write_o     = 1'b1;
               done_o         = 1'b1;
               branch_taken_o = zero_i ^ br_invert;
               state_d        = S_IDLE;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_read_o  = is_load;
            mem_write_o = is_store;
            if (mem_ready_i) begin
               if (is_store) begin
                  pc_write_o = 1'b1;
                  done_o     = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write_o = 1'b1;
            pc_write_o  = 1'b1;
            done_o      = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign alu_op_o    = alu_op_q;
   assign alu_src_b_o = alu_src_b_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         instr_q     <= '0;
         alu_op_q    <= OP_ADD;
         alu_src_b_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         alu_op_q    <= alu_op_d;
         alu_src_b_q <= alu_src_b_d;
      end
   end

endmodule

// File: doc/alu_ctrl_fsm.md
# alu_ctrl_fsm

Multicycle control sequencer that drives the ALU's operation-select interface. Accepts one RV32I instruction at a time over a valid/ready handshake, decodes it into a 4-bit ALU operation plus datapath strobes, steps it through DECODE/EXECUTE/MEM/WB states, and resolves branches from the ALU zero flag. Sits between the fetch stage and the ALU/register-file/data-memory datapath.

## Interface
- No parameters. ALU op encoding, fixed: ADD=0000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- instr_valid_i  in  1  instruction offered
- instr_i  in  32  instruction word
- instr_ready_o  out  1  block can accept an instruction
- zero_i  in  1  ALU zero flag (ALU result == 0)
- mem_ready_i  in  1  data memory completes access this cycle
- alu_op_o  out  4  operation select to ALU
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- reg_write_o  out  1  register-file write strobe
- mem_read_o / mem_write_o  out  1 each  data-memory request
- pc_write_o  out  1  PC update strobe
- branch_taken_o  out  1  valid when pc_write_o=1: 1 = branch target, 0 = PC+4
- done_o  out  1  instruction retired this cycle
- illegal_o  out  1  unsupported opcode/funct encoding, one-cycle pulse

## Operation
- States: IDLE, DECODE, EXECUTE, MEM, WB. Outputs are Moore-decoded from state and the captured instruction register, except branch_taken_o (also depends on zero_i in EXECUTE).
- IDLE: instr_ready_o=1. instr_valid_i && instr_ready_o captures instr_i -> DECODE. Otherwise stay.
- DECODE: register alu_op and alu_src_b from captured word. Supported opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH). Anything else, or R-type funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000,101}: illegal_o=1 for this cycle, -> IDLE, no other strobes.
- R-type alu_op = {funct7[5], funct3}. I-ALU: alu_op = {1'b0, funct3} except funct3=101 with instr[30]=1 -> SRA; ADDI never SUB. alu_src_b=1 for I-ALU/LOAD/STORE.
- LOAD/STORE: alu_op=ADD (address). BRANCH: BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; funct3 010/011 illegal.
- EXECUTE: R/I -> WB. LOAD/STORE -> MEM. BRANCH: pc_write_o=1, done_o=1, branch_taken_o = zero_i for BEQ/BGE/BGEU, !zero_i for BNE/BLT/BLTU; -> IDLE.
- MEM: mem_read_o (LOAD) or mem_write_o (STORE) held high until mem_ready_i=1. On mem_ready_i: STORE -> pc_write_o=1, done_o=1, -> IDLE; LOAD -> WB.
- WB: reg_write_o=1, pc_write_o=1, done_o=1 for one cycle, -> IDLE.
- alu_op_o stable from DECODE+1 until return to IDLE.

## Timing
- Reset (async, any state): state=IDLE, captured instr=0, alu_op_o=0000 (ADD), alu_src_b_o=0, all strobes 0, instr_ready_o=1 once reset deasserts.
- Accept on edge T: DECODE T+1, EXECUTE T+2. R/I: WB/done at T+3. Branch: done at T+2. Store: done at T+3 if mem_ready_i already high, +1 per wait cycle. Load: MEM T+3, WB one cycle after mem_ready_i.
- Next instruction accepted no earlier than cycle after done_o (or after illegal_o); instr_ready_o=0 outside IDLE.
- zero_i sampled only in EXECUTE of a branch; ignored elsewhere. mem_ready_i ignored outside MEM.
- Reset during MEM drops mem_read_o/mem_write_o same cycle (async); no done_o emitted.
- done_o, pc_write_o, reg_write_o, illegal_o never high more than one cycle per instruction.

## Test plan
- ADD x3,x1,x2 (0x002081B3) accepted -> alu_op_o=0000 from T+2, reg_write_o=done_o=pc_write_o=1 at T+3 only.
- SUB (0x402081B3) -> alu_op=1000; SRAI (0x4020D093) -> alu_op=1101, alu_src_b=1; ADDI with bit30=1 -> alu_op=0000.
- BNE (0x00209463) with zero_i=0 in EXECUTE -> branch_taken_o=1, done at T+2; repeat with zero_i=1 -> branch_taken_o=0; BGE with zero_i=1 -> taken.
- LW (0x0000A183) with mem_ready_i low 3 cycles -> mem_read_o high 4 cycles, reg_write_o one cycle after mem_ready_i; SW same, no reg_write_o.
- Opcode 0x7F and R-type funct7=0000001 -> illegal_o single pulse in DECODE, no write/pc strobes, instr_ready_o=1 next cycle.
- Assert rst_i mid-MEM of a store -> mem_write_o=0 immediately, alu_op_o=0000, no done_o; next instruction after deassert executes normally.
